// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and bit-timer sizing.
package uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    START  = S_START,
    DATA   = S_DATA,
    PARITY = S_PARITY,
    STOP   = S_STOP,
    BREAK  = S_BREAK
  } state_e;

  // Timer must hold CLKS_PER_BIT-1.
  function automatic int timer_w(input int clks_per_bit);
    return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector on the synchronized output.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic s1_q, s2_q, prev_q;

  // Reset to the idle (high) line level so reset itself never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign dout = s2_q;
  assign fall = prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parameterized UART receiver with ready/valid output, frame/parity/overrun flags.
// Optional parity bit compiled in with macro UART_RX_PARITY_EN.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  localparam int TW = timer_w(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD    = (PARITY_ODD != 0);

  logic rxs, fall;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rxd),
    .dout (rxs),
    .fall (fall)
  );

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, rx_ferr_q, rx_perr_q, rx_ovr_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fall) begin
          state_d = START;
          bit_d   = '0;
          perr_d  = 1'b0;
        end
      end
      START: if (timer_q == T_HALF) begin
        timer_d = '0;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (timer_q == T_FULL) begin
        // LSB arrives first; after DATA_BITS shifts bit n sits at index n.
        timer_d = '0;
        shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
        bit_d   = bit_q + BW'(1);
        if (bit_q == B_LAST) state_d = PAR_EN ? PARITY : STOP;
      end
      PARITY: if (timer_q == T_FULL) begin
        timer_d = '0;
        perr_d  = (^shreg_q) ^ rxs ^ ODD;
        state_d = STOP;
      end
      STOP: if (timer_q == T_FULL) begin
        timer_d = '0;
        ferr_d  = ~rxs;
        done_d  = 1'b1;
        state_d = rxs ? IDLE : BREAK;
      end
      BREAK: begin
        timer_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      done_q  <= done_d;
    end
  end

  // A completing frame is taken if the slot is empty or being drained this cycle; otherwise overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_q  <= shreg_q;
        rx_ferr_q  <= ferr_q;
        rx_perr_q  <= perr_q;
        rx_valid_q <= 1'b1;
        rx_ovr_q   <= 1'b0;
      end else begin
        rx_ovr_q <= 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_parity_err = PAR_EN ? rx_perr_q : 1'b0;
  assign rx_overrun    = rx_ovr_q;
  assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: frames are built bit by bit from the UART line rules,
// expected words are queued at send time and a monitor pops them on each handshake.
module tb_uart_rx_param;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // 2 sync flops + 1 detect edge, stop sample at (1.5+DB+P)*CPB later, valid one clock after.
  localparam int LAT = 2 + 1 + (3 * CPB) / 2 + (DB + P) * CPB + 1;

  logic          clk = 1'b0;
  logic          rst, rxd, rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_frame_err, rx_parity_err, rx_overrun, rx_busy;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(ODD)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_overrun    (rx_overrun),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DB-1:0] data;
    logic          ferr;
    logic          perr;
    logic          ovr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   last_rise = -1;
  logic valid_d = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: any handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rx_valid && !valid_d) last_rise = cyc;
    valid_d = rx_valid;
    if (!rst && rx_valid && rx_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word got=%0h want=none (cycle %0d)", rx_data, cyc);
      end else begin
        e = sb.pop_front();
        chk("word_data", 32'(rx_data), 32'(e.data));
        chk("word_ferr", 32'(rx_frame_err), 32'(e.ferr));
        chk("word_perr", 32'(rx_parity_err), 32'(e.perr));
        chk("word_ovr", 32'(rx_overrun), 32'(e.ovr));
      end
    end
  end

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge ending the stop bit with rxd still at the stop level.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic pflip,
                            input logic push, output int t0);
    exp_t e;
    logic pbit;
    pbit   = 1'(($countones(d) + ODD) % 2) ^ pflip;
    e.data = d;
    e.ferr = !stop;
    e.perr = (P != 0) ? (32'(($countones(d) + pbit) % 2) != ODD) : 1'b0;
    e.ovr  = 1'b0;
    if (push) sb.push_back(e);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (P != 0) drive_bit(pbit);
    drive_bit(stop);
  endtask

  task automatic chk_drained(input string nm);
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    chk(nm, sb.size(), 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_data"}, 32'(rx_data), 0);
    chk({nm, "_valid"}, 32'(rx_valid), 0);
    chk({nm, "_ferr"}, 32'(rx_frame_err), 0);
    chk({nm, "_perr"}, 32'(rx_parity_err), 0);
    chk({nm, "_ovr"}, 32'(rx_overrun), 0);
    chk({nm, "_busy"}, 32'(rx_busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    exp_t e;
    logic [DB-1:0] d;
    logic stop, flip;

    rst = 1'b1; rxd = 1'b1; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Good frame 0x55, timing from line edge to rx_valid.
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, t0);
    rxd = 1'b1;
    chk_drained("drain_55");
    chk("latency_55", 32'(last_rise - t0), 32'(LAT));
    repeat (4) @(negedge clk);
    chk("idle_valid_55", 32'(rx_valid), 0);

    // 3-clock glitch is rejected at the mid-start sample.
    t0 = cyc;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_hi", 32'(rx_busy), 1);
    repeat (6) @(negedge clk);
    chk("glitch_busy_lo", 32'(rx_busy), 0);
    chk("glitch_valid", 32'(rx_valid), 0);
    repeat (5) @(negedge clk);

    // Low stop bit, line held low: frame error then BREAK until the line returns high.
    send_frame(8'hA3, 1'b0, 1'b0, 1'b1, t0);
    repeat (40) @(negedge clk);
    chk("break_busy", 32'(rx_busy), 1);
    chk("break_drain", sb.size(), 0);
    chk("break_valid", 32'(rx_valid), 0);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    chk("break_exit", 32'(rx_busy), 0);

    // Back-to-back frames with no consumer: first word held, overrun raised.
    rx_ready = 1'b0;
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, t0);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0, t0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_valid", 32'(rx_valid), 1);
    chk("ovr_data", 32'(rx_data), 32'h12);
    chk("ovr_flag", 32'(rx_overrun), 1);
    e = '{data: 8'h12, ferr: 1'b0, perr: 1'b0, ovr: 1'b1};
    sb.push_back(e);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("ovr_clr_valid", 32'(rx_valid), 0);
    chk("ovr_clr_flag", 32'(rx_overrun), 0);
    chk_drained("drain_ovr");

`ifdef UART_RX_PARITY_EN
    // 0x07 with parity bit 0 (error) then parity bit 1 (clean).
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, t0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, t0);
    rxd = 1'b1;
    chk_drained("drain_par");
    repeat (3) @(negedge clk);
`endif

    // Reset in the middle of bit 4 drops the frame; the next one is received.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1, t0);
    rxd = 1'b1;
    chk_drained("drain_c3");
    repeat (3) @(negedge clk);

    // Random frames: data, occasional bad stop (with break hold), bad parity, idle gaps.
    for (int n = 0; n < 30; n++) begin
      d    = DB'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      flip = (P != 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
      send_frame(d, stop, flip, 1'b1, t0);
      if (!stop) repeat ($urandom_range(0, 30)) @(negedge clk);
      rxd = 1'b1;
      repeat ($urandom_range(2, 20)) @(negedge clk);
      chk_drained("drain_rand");
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
